three_phase_spwm: RTL
=====================

Name: three_phase_spwm

Overview:
- Downstream consumer of the frequency divider's active-low step strobe in the 3-phase induction motor drive.
- Each strobe advances a 96-entry sine phase index.
- Three phases 120° apart are amplitude-scaled and compared against a triangular carrier.
- Output is six complementary gate signals with dead-time insertion for the inverter bridge.

Parameters:
- TABLE_STEPS, 96, sine table entries per electrical period; must be divisible by 3.
- CARRIER_DIV, 4, clocks per carrier count step; must be ≥1.
- DEADTIME, 50, clocks with both gates of a leg low on every transition; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  bridge enable; 0 forces all gates low
- step_n  in  1  active-low step strobe from the frequency divider
- amp  in  8  modulation depth, 0..255 (255 ≈ full scale)
- ua_h, ua_l, ub_h, ub_l, uc_h, uc_l  out  1 each  high/low gate drives per leg
- idx  out  7  current phase-A table index, 0..TABLE_STEPS-1
- period_sync  out  1  one-cycle pulse when idx wraps to 0

Behaviour:
- Reset values:
  - idx=0, period_sync=0, all six gates=0.
  - Carrier=0, direction up; shadow duties=128.
  - Every leg FSM in DEAD with its counter loaded to DEADTIME.
- Step detect:
  - Register step_n; a step is prev=1 and cur=0 (falling edge only).
  - step_n held low counts once.
  - step_n low through reset counts no step until it returns high then low.
- Index update:
  - idx increments one cycle after the detected edge.
  - Wrap: idx=TABLE_STEPS-1 steps to 0, and period_sync=1 in that same cycle.
  - When en=0, steps are ignored and idx is held.
- Phase addresses:
  - A = idx.
  - B = (idx+TABLE_STEPS/3) mod TABLE_STEPS.
  - C = (idx+2*TABLE_STEPS/3) mod TABLE_STEPS.
- Sine table:
  - s[k] = round(127.5 + 127.5*sin(2πk/TABLE_STEPS)), clamped to 0..255.
  - For 96 entries: s[0]=128, s[24]=255, s[72]=0.
  - Synchronous read, 1-cycle latency.
- Scaling:
  - d = 128 + (((s-128) * amp) >>> 8).
  - s-128 is signed 9-bit, amp is zero-extended, product is signed 18-bit, shift is arithmetic (floor).
  - Result is always within 0..255. Example: amp=255 gives s=255→254 and s=0→0.
  - d is registered one cycle after the ROM output.
  - Total latency, step edge to d valid: 3 cycles.
- Carrier:
  - 8-bit triangle, advancing one count every CARRIER_DIV clocks.
  - Sequence 0→255 then 255→0; the turnaround counts are not repeated.
  - Period is 510*CARRIER_DIV clocks.
- Shadow duties:
  - Load from d only on the clock where the carrier is 0.
  - Duty never changes mid-carrier-period.
- Raw leg state: raw = (shadow_duty > carrier). Duty 0 is always low.
- Leg FSM, states LOW_ON, DEAD, HIGH_ON:
  - LOW_ON or HIGH_ON, with raw differing from the driven side → DEAD, counter reloaded to DEADTIME, both gates 0 from the next cycle.
  - DEAD: counter decrements each clock. At 0, enter HIGH_ON if raw=1 else LOW_ON, evaluated at expiry, not at entry.
  - A raw glitch during DEAD does not restart the counter.
  - Gates: h=1 only in HIGH_ON, l=1 only in LOW_ON.
  - h and l are never 1 together, under any input or reset sequence.
- en=0:
  - Next cycle all gates 0; every FSM forced to DEAD with the counter reloaded and held.
  - On en 0→1, DEADTIME clocks elapse before any gate asserts.
- rst asserted mid-operation: all gates 0 on the next cycle; all state returns to reset values.

Decomposition:
- Shared package:
  - Leg FSM state encoding.
  - TABLE_STEPS, sine midpoint 128, carrier width 8.
- Sub-module spwm_leg (instantiated 3×), containing:
  - The raw compare.
  - The dead-time FSM and counter.
  - The gate outputs.
- Sine ROM implemented as a synchronous case table. Either three read ports or a time-multiplexed single port is acceptable, provided the 3-cycle latency holds.

Test Plan:
- Reset: rst=1 for 3 clocks → all gates 0, idx=0, period_sync=0. After release with en=1, the first gate asserts no earlier than DEADTIME clocks.
- Edge counting:
  - step_n low for 10 clocks → idx 0→1 exactly once.
  - 5 clean one-cycle low pulses → idx=5.
  - Pulses with en=0 → idx unchanged.
- Wrap: 95 steps → idx=95; next step → idx=0 with period_sync=1 for exactly one clock. Check phase addresses B=32 and C=64 at idx=0.
- Scaling at idx=24 after a shadow load (phase A address 24, B address 56, C address 88):
  - amp=255 → duty A=254.
  - amp=0 → all three duties=128, giving ~50% gate duty per leg.
- Dead time, DEADTIME=50: force a raw transition → both gates of that leg low for exactly 50 clocks, then the opposite gate high. A raw pulse shorter than 50 clocks inside DEAD → FSM lands on the raw value at expiry.
- Enable drop: en 1→0 while ua_h=1 → ua_h=0 next clock. Re-enable → 50 clocks of all-low. Checker asserts h&l never 1 across a 200k-cycle random run of step_n, amp, en and rst.

Source files
------------

// File: rtl/three_phase_spwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : three_phase_spwm_pkg
//  Purpose  : Shared constants, leg state encoding, sine table and duty scaler
//             for the three-phase sinusoidal PWM generator.
//  Revision : 1.0
// ============================================================================
package three_phase_spwm_pkg;

    localparam int c_table_steps = 96;
    localparam int c_carrier_w   = 8;
    localparam logic [7:0] c_sine_mid = 8'd128;

    localparam logic [1:0] c_leg_low_on  = 2'd0;
    localparam logic [1:0] c_leg_dead    = 2'd1;
    localparam logic [1:0] c_leg_high_on = 2'd2;

    // First quarter (0..90 deg) of round(127.5 + 127.5*sin(2*pi*k/96)).
    function automatic logic [7:0] sine_quarter(input logic [4:0] q);
        logic [7:0] v;
        case (q)
            5'd0:    v = 8'd128;
            5'd1:    v = 8'd136;
            5'd2:    v = 8'd144;
            5'd3:    v = 8'd152;
            5'd4:    v = 8'd160;
            5'd5:    v = 8'd168;
            5'd6:    v = 8'd176;
            5'd7:    v = 8'd184;
            5'd8:    v = 8'd191;
            5'd9:    v = 8'd198;
            5'd10:   v = 8'd205;
            5'd11:   v = 8'd212;
            5'd12:   v = 8'd218;
            5'd13:   v = 8'd223;
            5'd14:   v = 8'd229;
            5'd15:   v = 8'd234;
            5'd16:   v = 8'd238;
            5'd17:   v = 8'd242;
            5'd18:   v = 8'd245;
            5'd19:   v = 8'd248;
            5'd20:   v = 8'd251;
            5'd21:   v = 8'd253;
            5'd22:   v = 8'd254;
            default: v = 8'd255;
        endcase
        return v;
    endfunction

    // Full 96-entry table folded onto the quarter wave; the negative half
    // mirrors as 255-v, except index 48 which is the 128 midpoint.
    function automatic logic [7:0] sine_lut(input logic [6:0] k);
        logic       neg;
        logic [6:0] j;
        logic [4:0] q;
        logic [7:0] v;
        neg = (k >= 7'd48);
        j   = neg ? (k - 7'd48) : k;
        q   = (j <= 7'd24) ? j[4:0] : 5'(7'd48 - j);
        v   = sine_quarter(q);
        if (neg && (q != 5'd0)) begin
            v = 8'd255 - v;
        end
        return v;
    endfunction

    // d = 128 + (((s-128) * amp) >>> 8), floor shift keeps d within 0..254.
    function automatic logic [7:0] scale_duty(input logic [7:0] s, input logic [7:0] a);
        logic signed [8:0]  diff;
        logic signed [17:0] prod;
        diff = $signed({1'b0, s}) - 9'sd128;
        prod = diff * $signed({1'b0, a});
        prod = prod >>> 8;
        return prod[7:0] + c_sine_mid;
    endfunction

endpackage
`default_nettype wire

// File: rtl/three_phase_spwm_leg.sv
`default_nettype none
// ============================================================================
//  Module   : spwm_leg
//  Purpose  : One inverter leg: carrier compare, dead-time FSM, gate drives.
//  Revision : 1.0
// ============================================================================
module spwm_leg
    import three_phase_spwm_pkg::*;
#(
    parameter int DEADTIME = 50
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    input  logic [c_carrier_w-1:0] i_duty,
    input  logic [c_carrier_w-1:0] i_carrier,
    output logic                   o_gate_h,
    output logic                   o_gate_l
);

    localparam int c_cnt_w = $clog2(DEADTIME + 1);
    localparam logic [c_cnt_w-1:0] c_dead_load = c_cnt_w'(DEADTIME);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_gate_h;
    logic               r_gate_l;
    logic               w_raw;

    assign w_raw = (i_duty > i_carrier);

    // The dead window closes on the clock the counter would reach 0, so the
    // leg spends exactly DEADTIME clocks with both gates low.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_state  <= c_leg_dead;
            r_cnt    <= c_dead_load;
            r_gate_h <= 1'b0;
            r_gate_l <= 1'b0;
        end else begin
            case (r_state)
                c_leg_low_on: begin
                    if (w_raw) begin
                        r_state  <= c_leg_dead;
                        r_cnt    <= c_dead_load;
                        r_gate_l <= 1'b0;
                    end
                end
                c_leg_high_on: begin
                    if (!w_raw) begin
                        r_state  <= c_leg_dead;
                        r_cnt    <= c_dead_load;
                        r_gate_h <= 1'b0;
                    end
                end
                c_leg_dead: begin
                    if (r_cnt <= c_cnt_one) begin
                        r_cnt <= '0;
                        if (w_raw) begin
                            r_state  <= c_leg_high_on;
                            r_gate_h <= 1'b1;
                            r_gate_l <= 1'b0;
                        end else begin
                            r_state  <= c_leg_low_on;
                            r_gate_h <= 1'b0;
                            r_gate_l <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state  <= c_leg_dead;
                    r_cnt    <= c_dead_load;
                    r_gate_h <= 1'b0;
                    r_gate_l <= 1'b0;
                end
            endcase
        end
    end

    assign o_gate_h = r_gate_h;
    assign o_gate_l = r_gate_l;

endmodule
`default_nettype wire

// File: rtl/three_phase_spwm.sv
`default_nettype none
// ============================================================================
//  Module   : three_phase_spwm
//  Purpose  : Step-driven three-phase sine PWM with dead-time gate outputs.
//  Revision : 1.0
// ============================================================================
module three_phase_spwm
    import three_phase_spwm_pkg::*;
#(
    parameter int TABLE_STEPS = c_table_steps,
    parameter int CARRIER_DIV = 4,
    parameter int DEADTIME    = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       step_n,
    input  logic [7:0] amp,
    output logic       ua_h,
    output logic       ua_l,
    output logic       ub_h,
    output logic       ub_l,
    output logic       uc_h,
    output logic       uc_l,
    output logic [6:0] idx,
    output logic       period_sync
);

    localparam int c_div_w = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CARRIER_DIV - 1);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [6:0] c_last_idx   = 7'(TABLE_STEPS - 1);
    localparam logic [7:0] c_steps8     = 8'(TABLE_STEPS);
    localparam logic [7:0] c_third8     = 8'(TABLE_STEPS / 3);
    localparam logic [7:0] c_two_third8 = 8'(2 * TABLE_STEPS / 3);

    logic                   r_step_prev;
    logic [6:0]             r_idx;
    logic                   r_sync;
    logic                   w_step;
    logic [7:0]             w_sum_b;
    logic [7:0]             w_sum_c;
    logic [6:0]             w_addr [3];
    logic [7:0]             r_sine [3];
    logic [7:0]             r_duty [3];
    logic [7:0]             r_shadow [3];
    logic [c_div_w-1:0]     r_div;
    logic [c_carrier_w-1:0] r_carrier;
    logic                   r_car_down;
    logic [2:0]             w_gate_h;
    logic [2:0]             w_gate_l;

    // Previous sample resets low so a strobe held low through reset is ignored.
    assign w_step = r_step_prev & ~step_n & en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_prev <= 1'b0;
            r_idx       <= 7'd0;
            r_sync      <= 1'b0;
        end else begin
            r_step_prev <= step_n;
            r_sync      <= 1'b0;
            if (w_step) begin
                if (r_idx == c_last_idx) begin
                    r_idx  <= 7'd0;
                    r_sync <= 1'b1;
                end else begin
                    r_idx <= r_idx + 7'd1;
                end
            end
        end
    end

    always_comb begin
        w_sum_b   = {1'b0, r_idx} + c_third8;
        w_sum_c   = {1'b0, r_idx} + c_two_third8;
        w_addr[0] = r_idx;
        w_addr[1] = (w_sum_b >= c_steps8) ? 7'(w_sum_b - c_steps8) : w_sum_b[6:0];
        w_addr[2] = (w_sum_c >= c_steps8) ? 7'(w_sum_c - c_steps8) : w_sum_c[6:0];
    end

    // Triangle carrier: 0..255..1 repeating, turnaround counts not doubled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_carrier  <= '0;
            r_car_down <= 1'b0;
        end else if (r_div == c_div_last) begin
            r_div <= '0;
            if (!r_car_down) begin
                if (r_carrier == 8'hFF) begin
                    r_car_down <= 1'b1;
                    r_carrier  <= 8'hFE;
                end else begin
                    r_carrier <= r_carrier + 8'd1;
                end
            end else begin
                if (r_carrier == 8'h00) begin
                    r_car_down <= 1'b0;
                    r_carrier  <= 8'h01;
                end else begin
                    r_carrier <= r_carrier - 8'd1;
                end
            end
        end else begin
            r_div <= r_div + c_div_one;
        end
    end

    // ROM read, amplitude scaling, then shadow capture only at carrier zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 3; p++) begin
                r_sine[p]   <= c_sine_mid;
                r_duty[p]   <= c_sine_mid;
                r_shadow[p] <= c_sine_mid;
            end
        end else begin
            for (int p = 0; p < 3; p++) begin
                r_sine[p] <= sine_lut(w_addr[p]);
                r_duty[p] <= scale_duty(r_sine[p], amp);
                if (r_carrier == 8'd0) begin
                    r_shadow[p] <= r_duty[p];
                end
            end
        end
    end

    for (genvar p = 0; p < 3; p++) begin : g_leg
        spwm_leg #(
            .DEADTIME (DEADTIME)
        ) u_leg (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en),
            .i_duty    (r_shadow[p]),
            .i_carrier (r_carrier),
            .o_gate_h  (w_gate_h[p]),
            .o_gate_l  (w_gate_l[p])
        );
    end

    assign ua_h        = w_gate_h[0];
    assign ua_l        = w_gate_l[0];
    assign ub_h        = w_gate_h[1];
    assign ub_l        = w_gate_l[1];
    assign uc_h        = w_gate_h[2];
    assign uc_l        = w_gate_l[2];
    assign idx         = r_idx;
    assign period_sync = r_sync;

endmodule
`default_nettype wire
